// File: rtl/branch_target_predictor_if.sv
// Fetch/execute <-> branch predictor signal bundle.
// master: fetch + execute side (drives lookup PC and resolved-branch updates).
// slave:  predictor (returns predicted PC and hit flag).
interface branch_target_predictor_if;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] prepc;
  logic        hit_predict;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_uncond;
  logic        fail_predict;

  modport master (
    output pc, stall, upd_en, upd_pc, upd_taken, upd_target, upd_uncond, fail_predict,
    input  prepc, hit_predict
  );

  modport slave (
    input  pc, stall, upd_en, upd_pc, upd_taken, upd_target, upd_uncond, fail_predict,
    output prepc, hit_predict
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and an unconditional flag.
// Combinational lookup from bus.pc, one-cycle update from the execute stage.
// Optional feature macro: BP_PERF_EN adds four 32-bit wrapping perf counters.
module branch_target_predictor #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  branch_target_predictor_if.slave    bus
`ifdef BP_PERF_EN
  ,
  output logic [31:0]                 perf_lookups,
  output logic [31:0]                 perf_hits,
  output logic [31:0]                 perf_updates,
  output logic [31:0]                 perf_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned TAG_LO  = INDEX_W + 2;
  localparam int unsigned TAG_HI  = TAG_W + INDEX_W + 1;

  logic               valid_q  [ENTRIES];
  logic               valid_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic               uncond_q [ENTRIES];
  logic               uncond_d [ENTRIES];

  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic               hit_c;
  logic               wr_match_c;

  assign rd_idx = bus.pc[INDEX_W+1:2];
  assign rd_tag = bus.pc[TAG_HI:TAG_LO];
  assign wr_idx = bus.upd_pc[INDEX_W+1:2];
  assign wr_tag = bus.upd_pc[TAG_HI:TAG_LO];

  // Lookup: sees stored contents only, never the in-flight update.
  always_comb begin
    hit_c = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) &&
            (uncond_q[rd_idx] || ctr_q[rd_idx][1]);
  end

  assign bus.hit_predict = hit_c;
  assign bus.prepc       = hit_c ? target_q[rd_idx] : bus.pc + 32'd4;

  // Training: counter/target refresh on tag match, allocate on taken miss.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    uncond_d   = uncond_q;
    wr_match_c = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    if (bus.upd_en) begin
      if (wr_match_c) begin
        if (bus.upd_taken) begin
          if (ctr_q[wr_idx] != 2'b11) ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
          target_d[wr_idx] = bus.upd_target;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
        end
        uncond_d[wr_idx] = bus.upd_uncond;
      end else if (bus.upd_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = bus.upd_target;
        uncond_d[wr_idx] = bus.upd_uncond;
        ctr_d[wr_idx]    = bus.upd_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  // BTB storage; reset leaves every entry invalid and weakly not-taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: 32'd0};
      ctr_q    <= '{default: 2'b01};
      uncond_q <= '{default: 1'b0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      uncond_q <= uncond_d;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] updates_q, updates_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  // Perf event counting; stall only gates the lookup-side counters.
  always_comb begin
    lookups_d     = lookups_q;
    hits_d        = hits_q;
    updates_d     = updates_q;
    mispredicts_d = mispredicts_q;
    if (!bus.stall)             lookups_d     = lookups_q + 32'd1;
    if (!bus.stall && hit_c)    hits_d        = hits_q + 32'd1;
    if (bus.upd_en)             updates_d     = updates_q + 32'd1;
    if (bus.fail_predict)       mispredicts_d = mispredicts_q + 32'd1;
  end

  // Perf counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lookups_q     <= 32'd0;
      hits_q        <= 32'd0;
      updates_q     <= 32'd0;
      mispredicts_q <= 32'd0;
    end else begin
      lookups_q     <= lookups_d;
      hits_q        <= hits_d;
      updates_q     <= updates_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign perf_lookups     = lookups_q;
  assign perf_hits        = hits_q;
  assign perf_updates     = updates_q;
  assign perf_mispredicts = mispredicts_q;

  logic unused_bits;
  assign unused_bits = ^{bus.pc[31:TAG_HI+1], bus.pc[1:0],
                         bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.pc[31:TAG_HI+1], bus.pc[1:0],
                         bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0],
                         bus.stall, bus.fail_predict};
`endif

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-side branch predictor producing the predicted next PC and hit flag consumed by the PC register of the instruction fetch stage. A direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters is looked up combinationally with the current fetch PC. It is trained by resolved-branch updates from the execute stage. Its outputs drive the fetch stage's predicted-PC and predict-hit inputs directly; on a misprediction the fetch stage is redirected separately via the execute stage.

## Interface
Parameters:
- INDEX_W, 6: BTB index width; 2^INDEX_W entries, indexed by pc[INDEX_W+1:2].
- TAG_W, 8: stored tag width, taken from pc[TAG_W+INDEX_W+1:INDEX_W+2].

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- pc  input  32  PC currently being fetched; lookup address.
- stall  input  1  fetch stall; suppresses performance lookup counting only.
- prepc  output  32  predicted next PC.
- hit_predict  output  1  predict-taken flag; fetch uses prepc when high.
- upd_en  input  1  execute stage resolved a control-transfer instruction this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  resolved direction.
- upd_target  input  32  resolved target address.
- upd_uncond  input  1  instruction is JAL/JALR (always taken).
- fail_predict  input  1  execute-stage mispredict pulse; used by perf counters only.

## Operation
- Entry fields: valid, tag[TAG_W], target[32], ctr[2], uncond.
- Lookup is combinational from pc:
  - hit = valid & (tag == pc tag field) & (uncond | ctr[1]).
  - hit_predict = hit.
  - prepc = hit ? target : pc + 4, with 32-bit wrap.
- Update on posedge when upd_en:
  - Tag match (valid & tag equal):
    - ctr saturating: +1 if upd_taken, −1 otherwise; 2'b11 stays on taken, 2'b00 stays on not-taken.
    - target <= upd_target if upd_taken.
    - uncond <= upd_uncond.
  - Miss and upd_taken: allocate (overwrite) the entry.
    - valid = 1, tag, target = upd_target, uncond = upd_uncond.
    - ctr = 2'b11 if upd_uncond, else 2'b10.
  - Miss and not taken: no change.
- Same-index lookup and update in one cycle: lookup sees the pre-update contents; the write becomes visible the next cycle. No bypass.
- stall has no effect on lookup or update.

## Timing
- Lookup latency 0 cycles (combinational); it must settle before the fetch PC register's posedge.
- Update latency 1 cycle; visible to a lookup in the cycle after the upd_en posedge.
- Reset (async, any time including mid-update):
  - All valid = 0, all ctr = 2'b01, uncond = 0, target = 0.
  - Outputs follow immediately: hit_predict = 0, prepc = pc + 4.
  - An update coincident with RST is discarded.
- Release of RST: first update is accepted on the first posedge with RST low.

## Configuration
- BP_PERF_EN defined: adds four 32-bit wrapping counters, cleared by RST and readable as outputs.
  - perf_lookups: +1 per cycle with !stall.
  - perf_hits: +1 per cycle with !stall & hit_predict.
  - perf_updates: +1 per upd_en.
  - perf_mispredicts: +1 per fail_predict.
- BP_PERF_EN undefined: counters and their output ports do not exist; prediction behaviour is identical.

## Test plan
- Reset, then pc=0x00008000 → hit_predict=0, prepc=0x00008004. Repeat with pc=0xFFFFFFFC → prepc=0x00000000 (wrap).
- upd_en with upd_pc=0x8010, taken, target 0x8040, upd_uncond=0 → from the next cycle, pc=0x8010 gives hit_predict=1, prepc=0x8040. Two not-taken updates (ctr 10→01→00) → hit_predict=0.
- Four taken updates to one entry → ctr saturates at 11. One not-taken update → still predicts 0x8040 (ctr 10).
- JAL update (upd_uncond=1, target 0x9000) at pc=0x8020, then three not-taken updates → hit_predict stays 1 (uncond overrides ctr) until a conditional update clears uncond.
- Alias: entry at 0x8010 valid; taken update at 0x8010 + (1<<(INDEX_W+2)) reallocates the index. Lookup at 0x8010 → miss, prepc=0x8014. A not-taken miss update allocates nothing.
- With BP_PERF_EN: 10 cycles, stall high on 3, hit on 4 unstalled, 2 upd_en, 1 fail_predict → lookups=7, hits=4, updates=2, mispredicts=1. Assert RST mid-run → all counters 0 immediately.
